// File: rtl/gen_queue_pkg.sv
`default_nettype none
// ============================================================================
// Module   : gen_queue_pkg
// Brief    : Shared types and constants for the generic queue reader.
// Revision : 1.0
// ============================================================================
package gen_queue_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } gq_state_e;

    // Output buffer capacity, sized for the occupancy compare in the reader.
    localparam logic [2:0] c_OBUF_ENTRIES = 3'd2;

endpackage
`default_nettype wire

// File: rtl/gen_queue_reader_obuf.sv
`default_nettype none
// ============================================================================
// Module   : gen_queue_reader_obuf
// Brief    : Two-entry in-order output buffer; head entry drives the stream.
// Revision : 1.0
// ============================================================================
module gen_queue_reader_obuf #(
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clr,
    input  logic              wr,
    input  logic              rd,
    input  logic [DATA_W-1:0] data,
    output logic [DATA_W-1:0] head,
    output logic [1:0]        count
);

    logic [DATA_W-1:0] r_mem [2];
    logic              r_wr_ptr;
    logic              r_rd_ptr;
    logic [1:0]        r_count;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_mem[0] <= '0;
            r_mem[1] <= '0;
            r_wr_ptr <= 1'b0;
            r_rd_ptr <= 1'b0;
            r_count  <= 2'd0;
        end else if (clr) begin
            r_mem[0] <= '0;
            r_mem[1] <= '0;
            r_wr_ptr <= 1'b0;
            r_rd_ptr <= 1'b0;
            r_count  <= 2'd0;
        end else begin
            if (wr) begin
                r_mem[r_wr_ptr] <= data;
                r_wr_ptr        <= ~r_wr_ptr;
            end
            if (rd) begin
                r_rd_ptr <= ~r_rd_ptr;
            end
            r_count <= r_count + {1'b0, wr} - {1'b0, rd};
        end
    end

    assign head  = r_mem[r_rd_ptr];
    assign count = r_count;

endmodule
`default_nettype wire

// File: rtl/gen_queue_reader.sv
`default_nettype none
// ============================================================================
// Module   : gen_queue_reader
// Brief    : Pops a configured burst from a queue and streams it out.
// Revision : 1.0
// ============================================================================
import gen_queue_pkg::*;

module gen_queue_reader #(
    parameter int DATA_W  = 8,
    parameter int DEPTH   = 100,
    parameter int SIM_DLY = 1,
    parameter int LEN_W   = $clog2(DEPTH + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              sw_rst,
    input  logic [LEN_W-1:0]  cnfg_burst_len,
    input  logic              start,
    output logic              busy,
    output logic              done,
    input  logic              q_empty,
    output logic              q_pop,
    input  logic [DATA_W-1:0] q_data,
    output logic              o_valid,
    input  logic              o_ready,
    output logic [DATA_W-1:0] o_data,
    output logic              o_last
);

    // SIM_DLY carries no function; this empty block only acknowledges it.
    if (SIM_DLY < 0) begin : g_sim_dly_unused
    end

    gq_state_e        r_state;
    logic [LEN_W-1:0] r_pop_cnt;
    logic [LEN_W-1:0] r_beat_cnt;
    logic             r_inflight;
    logic             r_done;

    logic [1:0]       w_buf_cnt;
    logic [2:0]       w_occ;
    logic             w_accept;
    logic             w_pop;
    logic             w_last_beat;

    assign w_accept    = o_valid & o_ready;
    // Occupancy the buffer will hold once in-flight data lands and this beat leaves.
    assign w_occ       = {1'b0, w_buf_cnt} + {2'b0, r_inflight} - {2'b0, w_accept};
    assign w_pop       = (r_state == RUN) && !sw_rst && !q_empty &&
                         (r_pop_cnt != '0) && (w_occ < c_OBUF_ENTRIES);
    assign w_last_beat = w_accept && (r_beat_cnt == LEN_W'(1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= IDLE;
            r_pop_cnt  <= '0;
            r_beat_cnt <= '0;
            r_inflight <= 1'b0;
            r_done     <= 1'b0;
        end else if (sw_rst) begin
            r_state    <= IDLE;
            r_pop_cnt  <= '0;
            r_beat_cnt <= '0;
            r_inflight <= 1'b0;
            r_done     <= 1'b0;
        end else begin
            r_inflight <= w_pop;
            r_done     <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (start) begin
                        if (cnfg_burst_len != '0) begin
                            r_pop_cnt  <= cnfg_burst_len;
                            r_beat_cnt <= cnfg_burst_len;
                            r_state    <= RUN;
                        end else begin
                            r_done <= 1'b1;
                        end
                    end
                end
                RUN: begin
                    if (w_pop) begin
                        r_pop_cnt <= r_pop_cnt - LEN_W'(1);
                        if (r_pop_cnt == LEN_W'(1)) begin
                            r_state <= DRAIN;
                        end
                    end
                end
                DRAIN: begin
                end
                default: r_state <= IDLE;
            endcase
            if (w_accept) begin
                r_beat_cnt <= r_beat_cnt - LEN_W'(1);
            end
            if (w_last_beat) begin
                r_state <= IDLE;
                r_done  <= 1'b1;
            end
        end
    end

    gen_queue_reader_obuf #(
        .DATA_W (DATA_W)
    ) u_obuf (
        .clk   (clk),
        .rst   (rst),
        .clr   (sw_rst),
        .wr    (r_inflight),
        .rd    (w_accept),
        .data  (q_data),
        .head  (o_data),
        .count (w_buf_cnt)
    );

    assign busy    = (r_state == RUN) || (r_state == DRAIN);
    assign done    = r_done;
    assign q_pop   = w_pop;
    assign o_valid = (w_buf_cnt != 2'd0);
    assign o_last  = o_valid && (r_beat_cnt == LEN_W'(1));

endmodule
`default_nettype wire

// File: tb/tb_gen_queue_reader.sv
`default_nettype none
// ============================================================================
// Module   : tb_gen_queue_reader
// Brief    : Self-checking bench: queue model, beat monitor, scenario tasks.
// Revision : 1.0
// ============================================================================
module tb_gen_queue_reader;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       sw_rst = 1'b0;
    logic [6:0] cnfg_burst_len = 7'd0;
    logic       start = 1'b0;
    logic       busy, done, q_pop, o_valid, o_last;
    logic       q_empty = 1'b1;
    logic [7:0] q_data = 8'h00;
    logic       o_ready = 1'b0;
    logic [7:0] o_data;

    int n_checks = 0;
    int n_fail   = 0;

    gen_queue_reader dut (
        .clk            (clk),
        .rst            (rst),
        .sw_rst         (sw_rst),
        .cnfg_burst_len (cnfg_burst_len),
        .start          (start),
        .busy           (busy),
        .done           (done),
        .q_empty        (q_empty),
        .q_pop          (q_pop),
        .q_data         (q_data),
        .o_valid        (o_valid),
        .o_ready        (o_ready),
        .o_data         (o_data),
        .o_last         (o_last)
    );

    always #5 clk = ~clk;

    // Queue model: data appears one clock after the pop; empty flag refreshed mid-cycle.
    logic [7:0] tbq [$];
    always @(posedge clk) begin
        if (q_pop && tbq.size() > 0) q_data <= tbq.pop_front();
        #2;
        q_empty <= (tbq.size() == 0);
    end

    // Monitor
    typedef struct packed { int c; logic last; logic [7:0] d; } beat_t;
    beat_t beats [$];
    int cyc = 0, n_pops = 0, n_done = 0, done_cyc = 0, start_cyc = 0, busy_cnt = 0;
    always @(negedge clk) begin
        cyc <= cyc + 1;
        if (q_pop) n_pops <= n_pops + 1;
        if (done) begin n_done <= n_done + 1; done_cyc <= cyc; end
        if (busy) busy_cnt <= busy_cnt + 1;
        if (start && !busy && !rst && !sw_rst) start_cyc <= cyc;
        if (o_valid && o_ready && !rst) beats.push_back('{c: cyc, last: o_last, d: o_data});
    end

    task automatic tick(); @(posedge clk); #1; endtask
    task automatic samp(); @(negedge clk); #1; endtask

    task automatic pulse_start(input int len);
        cnfg_burst_len = 7'(len);
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_done(input int d0, input int max, output bit to);
        int k = 0;
        while (n_done == d0 && k < max) begin samp(); k++; end
        to = (n_done == d0);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) tick();
        samp();
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy); end
        n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b want 0", done); end
        n_checks++; if (q_pop !== 1'b0) begin n_fail++; $display("FAIL reset_q_pop: got %b want 0", q_pop); end
        n_checks++; if (o_valid !== 1'b0) begin n_fail++; $display("FAIL reset_o_valid: got %b want 0", o_valid); end
        n_checks++; if (o_last !== 1'b0) begin n_fail++; $display("FAIL reset_o_last: got %b want 0", o_last); end
        n_checks++; if (o_data !== 8'h00) begin n_fail++; $display("FAIL reset_o_data: got %h want 00", o_data); end
        tick();
        rst = 1'b0;
        repeat (2) tick();
    endtask

    task automatic test_basic();
        logic [7:0] v [4];
        int p0, d0, b0; bit to;
        for (int i = 0; i < 4; i++) begin v[i] = 8'($urandom); tbq.push_back(v[i]); end
        p0 = n_pops; d0 = n_done; b0 = beats.size();
        o_ready = 1'b1;
        pulse_start(4);
        wait_done(d0, 40, to);
        n_checks++; if (to) begin n_fail++; $display("FAIL basic_timeout: no done within 40 clk"); end
        repeat (3) samp();
        n_checks++; if (beats.size() - b0 != 4) begin n_fail++; $display("FAIL basic_beats: got %0d want 4", beats.size() - b0); end
        if (beats.size() - b0 == 4) begin
            for (int i = 0; i < 4; i++) begin
                n_checks++; if (beats[b0+i].d !== v[i]) begin n_fail++; $display("FAIL basic_data[%0d]: got %h want %h", i, beats[b0+i].d, v[i]); end
                n_checks++; if (beats[b0+i].last !== (i == 3)) begin n_fail++; $display("FAIL basic_last[%0d]: got %b want %b", i, beats[b0+i].last, i == 3); end
                n_checks++; if (beats[b0+i].c != start_cyc + 3 + i) begin n_fail++; $display("FAIL basic_cycle[%0d]: got %0d want %0d", i, beats[b0+i].c, start_cyc + 3 + i); end
            end
            n_checks++; if (done_cyc != beats[b0+3].c + 1) begin n_fail++; $display("FAIL basic_done_cycle: got %0d want %0d", done_cyc, beats[b0+3].c + 1); end
        end
        n_checks++; if (n_done - d0 != 1) begin n_fail++; $display("FAIL basic_done_count: got %0d want 1", n_done - d0); end
        n_checks++; if (n_pops - p0 != 4) begin n_fail++; $display("FAIL basic_pops: got %0d want 4", n_pops - p0); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL basic_busy_after: got %b want 0", busy); end
    endtask

    task automatic test_backpressure();
        logic [7:0] v [3];
        int p0, d0, b0; bit to;
        for (int i = 0; i < 3; i++) begin v[i] = 8'($urandom); tbq.push_back(v[i]); end
        p0 = n_pops; d0 = n_done; b0 = beats.size();
        o_ready = 1'b0;
        pulse_start(3);
        repeat (10) begin
            samp();
            if (o_valid) begin
                n_checks++; if (o_data !== v[0]) begin n_fail++; $display("FAIL bp_hold: got %h want %h", o_data, v[0]); end
            end
        end
        n_checks++; if (o_valid !== 1'b1) begin n_fail++; $display("FAIL bp_valid: got %b want 1", o_valid); end
        n_checks++; if (n_pops - p0 != 2) begin n_fail++; $display("FAIL bp_pops_stalled: got %0d want 2", n_pops - p0); end
        tick();
        o_ready = 1'b1;
        wait_done(d0, 40, to);
        n_checks++; if (to) begin n_fail++; $display("FAIL bp_timeout: no done within 40 clk"); end
        repeat (2) samp();
        n_checks++; if (beats.size() - b0 != 3) begin n_fail++; $display("FAIL bp_beats: got %0d want 3", beats.size() - b0); end
        if (beats.size() - b0 == 3) begin
            for (int i = 0; i < 3; i++) begin
                n_checks++; if (beats[b0+i].d !== v[i]) begin n_fail++; $display("FAIL bp_data[%0d]: got %h want %h", i, beats[b0+i].d, v[i]); end
            end
        end
        n_checks++; if (n_pops - p0 != 3) begin n_fail++; $display("FAIL bp_pops: got %0d want 3", n_pops - p0); end
    endtask

    task automatic test_zero_len();
        int p0, d0, bc0;
        tick();
        p0 = n_pops; d0 = n_done; bc0 = busy_cnt;
        pulse_start(0);
        repeat (4) samp();
        n_checks++; if (n_pops != p0) begin n_fail++; $display("FAIL zero_pops: got %0d want 0", n_pops - p0); end
        n_checks++; if (busy_cnt != bc0) begin n_fail++; $display("FAIL zero_busy: busy seen %0d clk want 0", busy_cnt - bc0); end
        n_checks++; if (n_done - d0 != 1) begin n_fail++; $display("FAIL zero_done_count: got %0d want 1", n_done - d0); end
        n_checks++; if (done_cyc != start_cyc + 1) begin n_fail++; $display("FAIL zero_done_cycle: got %0d want %0d", done_cyc, start_cyc + 1); end
    endtask

    task automatic test_q_stall();
        logic [7:0] v [5];
        int p0, d0, b0; bit to;
        for (int i = 0; i < 5; i++) v[i] = 8'($urandom);
        tbq.push_back(v[0]); tbq.push_back(v[1]);
        p0 = n_pops; d0 = n_done; b0 = beats.size();
        o_ready = 1'b1;
        pulse_start(5);
        repeat (5) tick();
        samp();
        n_checks++; if (busy !== 1'b1 || o_valid !== 1'b0) begin n_fail++; $display("FAIL stall_hold: busy=%b o_valid=%b want 1/0", busy, o_valid); end
        tick();
        for (int i = 2; i < 5; i++) tbq.push_back(v[i]);
        wait_done(d0, 40, to);
        n_checks++; if (to) begin n_fail++; $display("FAIL stall_timeout: no done within 40 clk"); end
        repeat (3) samp();
        n_checks++; if (beats.size() - b0 != 5) begin n_fail++; $display("FAIL stall_beats: got %0d want 5", beats.size() - b0); end
        if (beats.size() - b0 == 5) begin
            for (int i = 0; i < 5; i++) begin
                n_checks++; if (beats[b0+i].d !== v[i]) begin n_fail++; $display("FAIL stall_data[%0d]: got %h want %h", i, beats[b0+i].d, v[i]); end
            end
        end
        n_checks++; if (n_done - d0 != 1) begin n_fail++; $display("FAIL stall_done_count: got %0d want 1", n_done - d0); end
        n_checks++; if (n_pops - p0 != 5) begin n_fail++; $display("FAIL stall_pops: got %0d want 5", n_pops - p0); end
    endtask

    task automatic test_sw_rst();
        logic [7:0] w [2];
        int p0, d0, b0; bit to;
        for (int i = 0; i < 4; i++) tbq.push_back(8'($urandom));
        p0 = n_pops; d0 = n_done;
        o_ready = 1'b0;
        pulse_start(4);
        repeat (6) samp();
        n_checks++; if (n_pops - p0 != 2 || o_valid !== 1'b1) begin n_fail++; $display("FAIL swrst_fill: pops=%0d valid=%b want 2/1", n_pops - p0, o_valid); end
        tick();
        sw_rst = 1'b1; o_ready = 1'b1;
        samp();
        n_checks++; if (q_pop !== 1'b0) begin n_fail++; $display("FAIL swrst_q_pop: got %b want 0", q_pop); end
        tick();
        sw_rst = 1'b0; o_ready = 1'b0;
        samp();
        n_checks++; if (busy !== 1'b0 || o_valid !== 1'b0 || o_last !== 1'b0) begin n_fail++; $display("FAIL swrst_state: busy=%b valid=%b last=%b want 0/0/0", busy, o_valid, o_last); end
        n_checks++; if (o_data !== 8'h00) begin n_fail++; $display("FAIL swrst_o_data: got %h want 00", o_data); end
        repeat (4) samp();
        n_checks++; if (n_done != d0) begin n_fail++; $display("FAIL swrst_no_done: got %0d want 0", n_done - d0); end
        tick();
        tbq.delete();
        for (int i = 0; i < 2; i++) begin w[i] = 8'($urandom); tbq.push_back(w[i]); end
        d0 = n_done; b0 = beats.size();
        o_ready = 1'b1;
        pulse_start(2);
        wait_done(d0, 40, to);
        n_checks++; if (to) begin n_fail++; $display("FAIL swrst_restart_timeout: no done within 40 clk"); end
        repeat (2) samp();
        n_checks++; if (beats.size() - b0 != 2) begin n_fail++; $display("FAIL swrst_restart_beats: got %0d want 2", beats.size() - b0); end
        if (beats.size() - b0 == 2) begin
            for (int i = 0; i < 2; i++) begin
                n_checks++; if (beats[b0+i].d !== w[i]) begin n_fail++; $display("FAIL swrst_restart_data[%0d]: got %h want %h", i, beats[b0+i].d, w[i]); end
            end
        end
    endtask

    task automatic test_busy_start();
        logic [7:0] v [8];
        int p0, d0, b0; bit to;
        for (int i = 0; i < 8; i++) begin v[i] = 8'($urandom); tbq.push_back(v[i]); end
        p0 = n_pops; d0 = n_done; b0 = beats.size();
        o_ready = 1'b1;
        pulse_start(3);
        tick();
        start = 1'b1; cnfg_burst_len = 7'd7;
        repeat (3) tick();
        start = 1'b0; cnfg_burst_len = 7'd5;
        wait_done(d0, 40, to);
        n_checks++; if (to) begin n_fail++; $display("FAIL busystart_timeout: no done within 40 clk"); end
        repeat (5) samp();
        n_checks++; if (beats.size() - b0 != 3) begin n_fail++; $display("FAIL busystart_beats: got %0d want 3", beats.size() - b0); end
        if (beats.size() - b0 == 3) begin
            for (int i = 0; i < 3; i++) begin
                n_checks++; if (beats[b0+i].d !== v[i]) begin n_fail++; $display("FAIL busystart_data[%0d]: got %h want %h", i, beats[b0+i].d, v[i]); end
            end
        end
        n_checks++; if (n_done - d0 != 1) begin n_fail++; $display("FAIL busystart_done_count: got %0d want 1", n_done - d0); end
        n_checks++; if (n_pops - p0 != 3) begin n_fail++; $display("FAIL busystart_pops: got %0d want 3", n_pops - p0); end
        tick();
        tbq.delete();
        tick();
    endtask

    task automatic test_random();
        for (int it = 0; it < 6; it++) begin
            logic [7:0] v [$];
            int len, idx, t, p0, d0, b0;
            len = $urandom_range(1, 8);
            v.delete();
            for (int i = 0; i < len; i++) v.push_back(8'($urandom));
            idx = $urandom_range(0, len);
            for (int i = 0; i < idx; i++) tbq.push_back(v[i]);
            p0 = n_pops; d0 = n_done; b0 = beats.size();
            o_ready = 1'($urandom_range(0, 1));
            pulse_start(len);
            t = 0;
            while ((n_done == d0 || idx < len) && t < 300) begin
                o_ready = ($urandom_range(0, 3) != 0);
                if (idx < len && $urandom_range(0, 2) == 0) begin tbq.push_back(v[idx]); idx++; end
                tick();
                t++;
            end
            o_ready = 1'b1;
            repeat (3) samp();
            n_checks++; if (t >= 300) begin n_fail++; $display("FAIL rand%0d_timeout: burst not done in 300 clk", it); end
            n_checks++; if (beats.size() - b0 != len) begin n_fail++; $display("FAIL rand%0d_beats: got %0d want %0d", it, beats.size() - b0, len); end
            if (beats.size() - b0 == len) begin
                for (int i = 0; i < len; i++) begin
                    n_checks++; if (beats[b0+i].d !== v[i] || beats[b0+i].last !== (i == len - 1)) begin
                        n_fail++; $display("FAIL rand%0d_beat[%0d]: got %h/%b want %h/%b", it, i, beats[b0+i].d, beats[b0+i].last, v[i], i == len - 1);
                    end
                end
            end
            n_checks++; if (n_done - d0 != 1 || n_pops - p0 != len) begin n_fail++; $display("FAIL rand%0d_counts: done=%0d pops=%0d want 1/%0d", it, n_done - d0, n_pops - p0, len); end
        end
    endtask

    task automatic test_async_rst();
        for (int i = 0; i < 3; i++) tbq.push_back(8'($urandom));
        o_ready = 1'b0;
        pulse_start(3);
        repeat (5) samp();
        rst = 1'b1;
        #1;
        n_checks++; if (busy !== 1'b0 || o_valid !== 1'b0 || q_pop !== 1'b0) begin n_fail++; $display("FAIL async_rst: busy=%b valid=%b pop=%b want 0/0/0", busy, o_valid, q_pop); end
        tick();
        tbq.delete();
        rst = 1'b0;
        repeat (2) tick();
    endtask

    initial begin
        test_reset();
        test_basic();
        test_backpressure();
        test_zero_len();
        test_q_stall();
        test_sw_rst();
        test_busy_start();
        test_random();
        test_async_rst();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire

// File: doc/gen_queue_reader.md
GEN_QUEUE_READER -- requirements
Module: gen_queue_reader

Interface
REQ-001 SHALL have parameter DATA_W, default 8: data width, equal to the attached queue's DATA_W.
REQ-002 SHALL have parameter DEPTH, default 100: attached queue depth; bounds the burst length.
REQ-003 SHALL have parameter SIM_DLY, default 1: simulation delay only, no functional effect.
REQ-004 SHALL have parameter LEN_W, default $clog2(DEPTH+1): burst-length width (local, do not override).
REQ-005 SHALL have port clk, input, 1: single clock, all logic on posedge.
REQ-006 SHALL have port rst, input, 1: reset, asynchronous, active-high.
REQ-007 SHALL have port sw_rst, input, 1: synchronous soft reset, active-high.
REQ-008 SHALL have port cnfg_burst_len, input, LEN_W: entries to drain per start; sampled on accepted start.
REQ-009 SHALL have port start, input, 1: burst request pulse.
REQ-010 SHALL have port busy, output, 1: high while a burst is in progress.
REQ-011 SHALL have port done, output, 1: one-cycle pulse on burst completion.
REQ-012 SHALL have port q_empty, input, 1: queue empty flag.
REQ-013 SHALL have port q_pop, output, 1: queue pop request.
REQ-014 SHALL have port q_data, input, DATA_W: queue read data, valid exactly 1 clk after q_pop.
REQ-015 SHALL have port o_valid, output, 1: stream output valid.
REQ-016 SHALL have port o_ready, input, 1: stream output ready.
REQ-017 SHALL have port o_data, output, DATA_W: stream output data.
REQ-018 SHALL have port o_last, output, 1: marks the final beat of a burst.

Function
REQ-019 SHALL implement an FSM with states IDLE, RUN and DRAIN.
REQ-020 In IDLE, start with cnfg_burst_len!=0 SHALL load pop_cnt=cnfg_burst_len and beat_cnt=cnfg_burst_len, and move to RUN next cycle.
REQ-021 In IDLE, start with cnfg_burst_len==0 SHALL stay in IDLE, issue no pop, and pulse done on the next cycle.
REQ-022 start SHALL be ignored while busy=1 (RUN or DRAIN).
REQ-023 busy SHALL be 1 exactly when the state is RUN or DRAIN.
REQ-024 q_pop SHALL be asserted combinationally in RUN only when: ~q_empty; pop_cnt!=0; and (buf_cnt + inflight - (o_valid&o_ready)) < 2.
REQ-025 Each q_pop SHALL decrement pop_cnt; RUN SHALL move to DRAIN in the cycle after the pop that brings pop_cnt to 0.
REQ-026 q_data SHALL be written into a 2-entry output buffer one cycle after each q_pop; inflight SHALL be a 1-bit register equal to the previous cycle's q_pop.
REQ-027 The output buffer SHALL never overflow; o_data/o_valid SHALL come from its head entry, in order, with no reordering or duplication.
REQ-028 Simultaneous buffer write and o_valid&o_ready SHALL leave buf_cnt unchanged.
REQ-029 Each o_valid&o_ready beat SHALL decrement beat_cnt; o_last SHALL equal o_valid&&(beat_cnt==1).
REQ-030 When the beat with o_last is accepted, the FSM SHALL return to IDLE and pulse done on the next cycle.
REQ-031 o_data SHALL hold stable while o_valid&~o_ready.
REQ-032 Sustained throughput SHALL be 1 beat/clk when q_empty=0 and o_ready=1; first-beat latency from accepted start SHALL be 3 clk (RUN entry, pop, buffer write).
REQ-033 A q_empty assertion mid-burst SHALL stall pops only; the state and counters SHALL be held.

Reset
REQ-034 rst SHALL asynchronously force IDLE, pop_cnt=0, beat_cnt=0, buf_cnt=0 and inflight=0, with outputs busy=0, done=0, q_pop=0, o_valid=0, o_last=0 and o_data=0.
REQ-035 sw_rst SHALL produce the same state on the next clk edge, discarding buffered or in-flight data without a done pulse; q_pop SHALL be 0 while sw_rst=1.

Structure
REQ-036 The state enum typedef (IDLE/RUN/DRAIN) SHALL reside in the shared package gen_queue_pkg.
REQ-037 The 2-entry output buffer SHALL be sub-module gen_queue_reader_obuf (DATA_W param; wr, rd, data, count).

Verification
REQ-038 Verification SHALL cover: len=4, queue holding A,B,C,D, o_ready=1 -> o_data A,B,C,D on 4 consecutive clk, o_last with D, done 1 clk later.
REQ-039 Verification SHALL cover: len=3, o_ready=0 for 10 clk -> exactly 2 pops issued, o_data holds the first entry; after o_ready rises, all 3 beats arrive in order.
REQ-040 Verification SHALL cover: len=0 start -> no q_pop, busy stays 0, done pulses once.
REQ-041 Verification SHALL cover: len=5, queue holding 2 entries, 3 more pushed 6 clk later -> pops stall on q_empty, 5 beats delivered in order, single done.
REQ-042 Verification SHALL cover: sw_rst mid-burst with buf_cnt=2 -> next clk IDLE, o_valid=0, no done; a new start then works normally.
REQ-043 Verification SHALL cover: start asserted while busy -> ignored; cnfg_burst_len changes mid-burst -> burst length unaffected.
